// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and decode helpers for the load/store unit.
package lsu_pkg;

    // MemOP encodings: op[1:0] is the access size, op[2] selects zero-extension.
    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Response error codes.
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    // FSM state encoding.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    typedef enum logic [1:0] {
        LSU_IDLE = S_IDLE,
        LSU_REQ  = S_REQ,
        LSU_WAIT = S_WAIT,
        LSU_RESP = S_RESP
    } lsu_state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    function automatic logic op_legal(input logic [2:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    // Only meaningful for legal ops.
    function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        return ((op[1:0] == SZ_HALF) && addr_lo[0]) ||
               ((op[1:0] == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store strobes/replication and load extraction.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  op,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store side: replicate the datum across lanes and enable only the addressed lanes.
    always_comb begin
        wstrb      = 4'b1111;
        lane_wdata = wdata;
        case (op[1:0])
            SZ_BYTE: begin
                wstrb      = 4'b0001 << addr_lo;
                lane_wdata = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: pick the addressed byte/half, then sign- or zero-extend.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        case (op[1:0])
            SZ_BYTE: load_data = {{24{~op[2] & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{16{~op[2] & half_sel[15]}}, half_sel};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_unit.sv
// Load/store unit: one data-bus transaction per accepted access, with
// alignment checks, lane steering, load extension and a bus timeout.
module lsu_mem_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [1:0]        resp_err,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        op_q, op_d;
    logic              wr_q, wr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        err_q, err_d;
    logic              timed_out;

    logic [3:0]        lane_strb;
    logic [31:0]       lane_wdata;
    logic [31:0]       load_data;

    lsu_align u_align (
        .addr_lo    (addr_q[1:0]),
        .op         (op_q),
        .wdata      (wdata_q),
        .rdata      (mem_rdata),
        .wstrb      (lane_strb),
        .lane_wdata (lane_wdata),
        .load_data  (load_data)
    );

    // The counter starts at 1 on accept so a hung access responds exactly
    // TIMEOUT cycles after it was accepted.
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign timed_out = (cnt_inc >= CNT_W'(TIMEOUT));

    // Next-state logic: accept/check in IDLE, bus handshake in REQ/WAIT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        op_d    = op_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    op_d    = req_op;
                    wr_d    = req_wr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    cnt_d   = CNT_W'(1);
                    if (!op_legal(req_op)) begin
                        err_d   = ERR_ILLEGAL;
                        state_d = S_RESP;
                    end else if (op_misaligned(req_op, req_addr[1:0])) begin
                        err_d   = ERR_MISALIGN;
                        state_d = S_RESP;
                    end else begin
                        err_d   = ERR_NONE;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_inc;
                if (mem_gnt) begin
                    state_d = wr_q ? S_RESP : S_WAIT;
                end else if (timed_out) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (mem_rvalid) begin
                    rdata_d = load_data;
                    state_d = S_RESP;
                end else if (timed_out) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and latched request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            op_q    <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode straight from state so reset clears them asynchronously.
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        busy       = (state_q != S_IDLE);
        mem_req    = (state_q == S_REQ);
        mem_we     = mem_req & wr_q;
        mem_addr   = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        mem_wstrb  = mem_req ? lane_strb : 4'b0000;
        mem_wdata  = mem_req ? lane_wdata : 32'h0;
        resp_valid = (state_q == S_RESP);
        resp_rdata = resp_valid ? rdata_q : 32'h0;
        resp_err   = resp_valid ? err_q : ERR_NONE;
    end

endmodule

// File: doc/lsu_mem_unit.md
Name: lsu_mem_unit

Overview:
- Load/store unit directly downstream of instruction decode. Consumes MemWr/MemOP-style controls plus the ALU-computed address and rs2 data. Issues one request on the data-memory bus and returns aligned, sign/zero-extended load data.
- Multi-cycle handshake with a stall (busy) output, so the core can hold PC while memory is slow.
- Detects misaligned and illegal-op accesses, and times out a hung bus.

Parameters:
- ADDR_W, 32, byte address width.
- TIMEOUT, 255, max cycles spent in REQ+WAIT before a bus-error response; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  decode/execute presents an access.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_wr  in  1  1=store (MemWr), 0=load.
- req_op  in  3  MemOP: 010 word, 001 half signed, 000 byte signed, 101 half unsigned, 100 byte unsigned; others illegal.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data (rs2).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  2  00 ok, 01 misaligned, 10 illegal op, 11 bus timeout; valid with resp_valid.
- busy  out  1  state != IDLE; core stall.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write enable.
- mem_addr  out  ADDR_W  word-aligned address, low 2 bits 0.
- mem_wstrb  out  4  byte-lane strobes.
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  bus accepts the request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.

Behaviour:
- States: IDLE, REQ, WAIT, RESP. Async reset forces IDLE; resp_valid, resp_rdata, resp_err, mem_req, mem_we, mem_addr, mem_wstrb and mem_wdata are all 0. req_ready=1 and busy=0 once rst_n deasserts.
- IDLE:
  - Accept on req_valid & req_ready; latch addr, op, wr and wdata.
  - Illegal op, or misaligned access: go to RESP with the error code and no mem_req. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0. Illegal is checked before misaligned.
  - Otherwise go to REQ.
- REQ:
  - mem_req=1; addr, we, wstrb and wdata stay stable until mem_gnt.
  - On gnt, a store goes to RESP and a load goes to WAIT.
  - mem_req drops the cycle after gnt.
- WAIT: on mem_rvalid, register the extracted data and go to RESP. mem_rvalid is never sampled in the gnt cycle.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. There is no response back-pressure. Minimum latency from accept to resp_valid: error=1 cycle, store with immediate gnt=2, load=3.
- Store alignment:
  - Byte: wdata[7:0] replicated to all 4 lanes; wstrb = 0001 << addr[1:0].
  - Half: {2{wdata[15:0]}}; wstrb 0011 if addr[1]=0, else 1100.
  - Word: wstrb 1111.
- Load extraction: select the byte by addr[1:0] or the half by addr[1], then sign- or zero-extend per op.
- Timeout:
  - Counter clears on accept and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT: drop mem_req, go to RESP with err=11 and rdata=0.
  - A stray mem_rvalid while in IDLE, REQ or RESP is ignored.
- Reset mid-operation aborts immediately; mem_req falls asynchronously. No response is produced for the aborted access.
- req_valid while busy is not accepted; the upstream holds it.

Decomposition:
- lsu_pkg:
  - MemOP encodings (OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU).
  - Error codes.
  - lsu_state_t enum.
  - Default TIMEOUT.
- Sub-module lsu_align: purely combinational.
  - Store side: addr[1:0], op, wdata -> wstrb, lane data.
  - Load side: rdata, addr[1:0], op -> extended result.
  - Shared with future cache work.

Test Plan:
- Store byte: op=000, wr=1, addr=0x1003, wdata=0x000000A5, gnt immediate -> mem_addr=0x1000, wstrb=1000, wdata=0xA5A5A5A5; resp_valid 2 cycles after accept, err=00.
- Load half signed: op=001, addr=0x2002, rdata=0x8001_1234, rvalid 2 cycles after gnt -> resp_rdata=0xFFFF8001. Repeat with op=101 -> 0x00008001.
- Misaligned word: op=010, addr=0x3001 -> no mem_req; resp_valid next cycle, err=01, rdata=0. Illegal op=011 -> err=10.
- Gnt stall: mem_gnt low 5 cycles -> mem_req and all mem_* signals stable throughout, busy=1, req_ready=0; completes after gnt.
- Timeout with TIMEOUT=8: load granted, no rvalid -> resp_valid with err=11 exactly 8 cycles after accept; a later rvalid in IDLE causes no response.
- Reset in WAIT: rst_n low mid-load -> mem_req=0 and busy=0 immediately, no resp_valid; after release, a new word load at 0x0 completes normally.
